// File: rtl/strela_csr_pkg.sv
// Shared register map, bus structs and state encoding for the STRELA test-path CSR block.
// Offsets are byte offsets within the decoded low address window.
package strela_csr_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam logic [31:0] CTRL_OFFS    = 32'h00;
  localparam logic [31:0] STATUS_OFFS  = 32'h04;
  localparam logic [31:0] CYCLES_OFFS  = 32'h08;
  localparam logic [31:0] VERSION_OFFS = 32'h0C;
  localparam logic [31:0] CH_BASE_OFFS = 32'h10;
  localparam logic [31:0] CH_STRIDE    = 32'h08;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_SOFT_CLR_BIT = 2;
  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;

  typedef enum logic {IDLE, RUN} ctrl_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/strela_csr_fsm.sv
// Execute/busy/done sequencer: one-cycle start pulse, saturating run-cycle counter, sticky DONE.
// SOFT_CLR beats START; a completion set beats a same-cycle W1C.
module strela_csr_fsm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        clr_i,
  input  logic        w1c_i,
  input  logic        done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        execute_o,
  output logic [31:0] cycles_o
);
  import strela_csr_pkg::*;

  ctrl_state_e state_q, state_d;
  logic        exec_q, exec_d;
  logic        done_q, done_d;
  logic [31:0] cyc_q, cyc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      exec_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      exec_q  <= exec_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exec_d  = 1'b0;
    done_d  = done_q;
    cyc_d   = cyc_q;

    if (state_q == RUN && cyc_q != '1) cyc_d = cyc_q + 32'd1;
    if (w1c_i) done_d = 1'b0;

    if (clr_i) begin
      // abort keeps the last count visible for post-mortem reads
      state_d = IDLE;
      done_d  = 1'b0;
      cyc_d   = cyc_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            exec_d  = 1'b1;
            cyc_d   = '0;
            done_d  = 1'b0;
          end
        end
        RUN: begin
          if (done_i) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;
  assign execute_o = exec_q;
  assign cycles_o  = cyc_q;

endmodule

// File: rtl/strela_csr_ctrl.sv
// Register-bus CSR block: per-channel stream descriptors plus execute/busy/done control.
// Zero-wait combinational reads; channel writes are silently dropped while a run is active.
module strela_csr_ctrl #(
  parameter type         reg_req_t        = strela_csr_pkg::reg_req_t,
  parameter type         reg_rsp_t        = strela_csr_pkg::reg_rsp_t,
  parameter int unsigned INPUT_NODES_NUM  = 4,
  parameter int unsigned OUTPUT_NODES_NUM = 4,
  parameter int unsigned ADDR_DECODE_W    = 10,
  parameter logic [7:0]  HW_VERSION       = 8'h02
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  reg_req_t                           reg_req_i,
  output reg_rsp_t                           reg_rsp_o,
  output logic [INPUT_NODES_NUM-1:0][31:0]   data_input_addr_o,
  output logic [INPUT_NODES_NUM-1:0][15:0]   data_input_size_o,
  output logic [INPUT_NODES_NUM-1:0][15:0]   data_input_stride_o,
  output logic [OUTPUT_NODES_NUM-1:0][31:0]  data_output_addr_o,
  output logic [OUTPUT_NODES_NUM-1:0][15:0]  data_output_size_o,
  output logic                               execute_o,
  input  logic                               done_i,
  output logic                               busy_o,
  output logic                               irq_o
);
  import strela_csr_pkg::*;

  localparam int unsigned NCH         = INPUT_NODES_NUM + OUTPUT_NODES_NUM;
  localparam logic [31:0] VERSION_VAL = {8'(INPUT_NODES_NUM), 8'(OUTPUT_NODES_NUM), 8'h00, HW_VERSION};

  logic [INPUT_NODES_NUM-1:0][31:0]  in_addr_q;
  logic [INPUT_NODES_NUM-1:0][15:0]  in_size_q, in_stride_q;
  logic [OUTPUT_NODES_NUM-1:0][31:0] out_addr_q;
  logic [OUTPUT_NODES_NUM-1:0][15:0] out_size_q;
  logic                              irq_en_q;

  logic [31:0] off, ch_rel, ch_idx, cur_word, wr_word, cycles;
  logic        ch_hi, aligned, is_ch, mapped, wr_en;
  logic        ctrl_wr, status_wr, busy, done_sticky;

  assign off     = 32'(reg_req_i.addr[ADDR_DECODE_W-1:0]);
  assign ch_rel  = off - CH_BASE_OFFS;
  assign ch_idx  = ch_rel >> 3;
  assign ch_hi   = ch_rel[2];
  assign aligned = (off[1:0] == 2'b00);
  assign is_ch   = (off >= CH_BASE_OFFS) && (ch_idx < 32'(NCH));

  // cur_word doubles as the read value and the merge base for strobed writes
  always_comb begin
    cur_word = '0;
    mapped   = 1'b0;
    if (aligned) begin
      if (off == CTRL_OFFS) begin
        mapped                    = 1'b1;
        cur_word[CTRL_IRQ_EN_BIT] = irq_en_q;
      end else if (off == STATUS_OFFS) begin
        mapped                    = 1'b1;
        cur_word[STATUS_BUSY_BIT] = busy;
        cur_word[STATUS_DONE_BIT] = done_sticky;
      end else if (off == CYCLES_OFFS) begin
        mapped   = 1'b1;
        cur_word = cycles;
      end else if (off == VERSION_OFFS) begin
        mapped   = 1'b1;
        cur_word = VERSION_VAL;
      end else if (is_ch) begin
        mapped = 1'b1;
        for (int i = 0; i < INPUT_NODES_NUM; i++) begin
          if (ch_idx == 32'(i)) cur_word = ch_hi ? {in_stride_q[i], in_size_q[i]} : in_addr_q[i];
        end
        for (int j = 0; j < OUTPUT_NODES_NUM; j++) begin
          if (ch_idx == 32'(INPUT_NODES_NUM + j)) cur_word = ch_hi ? {16'h0, out_size_q[j]} : out_addr_q[j];
        end
      end
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid & ~mapped;
    reg_rsp_o.rdata = (reg_req_i.valid & mapped) ? cur_word : 32'h0;
  end

  assign wr_en     = reg_req_i.valid & reg_req_i.write & mapped;
  assign ctrl_wr   = wr_en & (off == CTRL_OFFS) & reg_req_i.wstrb[0];
  assign status_wr = wr_en & (off == STATUS_OFFS) & reg_req_i.wstrb[0];
  assign wr_word   = apply_wstrb(cur_word, reg_req_i.wdata, reg_req_i.wstrb);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_addr_q   <= '0;
      in_size_q   <= '0;
      in_stride_q <= '0;
      out_addr_q  <= '0;
      out_size_q  <= '0;
      irq_en_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= reg_req_i.wdata[CTRL_IRQ_EN_BIT];
      if (wr_en && is_ch && !busy) begin
        for (int i = 0; i < INPUT_NODES_NUM; i++) begin
          if (ch_idx == 32'(i)) begin
            if (ch_hi) {in_stride_q[i], in_size_q[i]} <= wr_word;
            else       in_addr_q[i]                   <= wr_word;
          end
        end
        for (int j = 0; j < OUTPUT_NODES_NUM; j++) begin
          if (ch_idx == 32'(INPUT_NODES_NUM + j)) begin
            if (ch_hi) out_size_q[j] <= wr_word[15:0];
            else       out_addr_q[j] <= wr_word;
          end
        end
      end
    end
  end

  strela_csr_fsm u_fsm (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (ctrl_wr & reg_req_i.wdata[CTRL_START_BIT]),
    .clr_i     (ctrl_wr & reg_req_i.wdata[CTRL_SOFT_CLR_BIT]),
    .w1c_i     (status_wr & reg_req_i.wdata[STATUS_DONE_BIT]),
    .done_i    (done_i),
    .busy_o    (busy),
    .done_o    (done_sticky),
    .execute_o (execute_o),
    .cycles_o  (cycles)
  );

  assign busy_o              = busy;
  assign irq_o               = done_sticky & irq_en_q;
  assign data_input_addr_o   = in_addr_q;
  assign data_input_size_o   = in_size_q;
  assign data_input_stride_o = in_stride_q;
  assign data_output_addr_o  = out_addr_q;
  assign data_output_size_o  = out_size_q;

endmodule

// File: tb/tb_strela_csr_ctrl.sv
// Directed + randomized bench for strela_csr_ctrl against a behavioural address-map model.
module tb_strela_csr_ctrl;
  import strela_csr_pkg::*;

  localparam int NI = 2;
  localparam int NO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_req_t req, reqb;
  reg_rsp_t rsp, rspb;
  logic [NI-1:0][31:0] in_addr;
  logic [NI-1:0][15:0] in_size, in_stride;
  logic [NO-1:0][31:0] out_addr;
  logic [NO-1:0][15:0] out_size;
  logic execute, done_in, busy, irq;

  logic [3:0][31:0] b_in_addr, b_out_addr;
  logic [3:0][15:0] b_in_size, b_in_stride, b_out_size;
  logic b_exec, b_busy, b_irq;

  strela_csr_ctrl #(.INPUT_NODES_NUM(NI), .OUTPUT_NODES_NUM(NO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp),
    .data_input_addr_o(in_addr), .data_input_size_o(in_size), .data_input_stride_o(in_stride),
    .data_output_addr_o(out_addr), .data_output_size_o(out_size),
    .execute_o(execute), .done_i(done_in), .busy_o(busy), .irq_o(irq));

  strela_csr_ctrl dut_dflt (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(reqb), .reg_rsp_o(rspb),
    .data_input_addr_o(b_in_addr), .data_input_size_o(b_in_size), .data_input_stride_o(b_in_stride),
    .data_output_addr_o(b_out_addr), .data_output_size_o(b_out_size),
    .execute_o(b_exec), .done_i(1'b0), .busy_o(b_busy), .irq_o(b_irq));

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_in_addr [NI];
  logic [15:0] m_in_size [NI], m_in_stride [NI];
  logic [31:0] m_out_addr [NO];
  logic [15:0] m_out_size [NO];
  logic        m_irq_en, m_done, m_busy;
  logic [31:0] m_cycles;

  logic        last_err;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin m_in_addr[i] = 0; m_in_size[i] = 0; m_in_stride[i] = 0; end
    for (int j = 0; j < NO; j++) begin m_out_addr[j] = 0; m_out_size[j] = 0; end
    m_irq_en = 0; m_done = 0; m_busy = 0; m_cycles = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // {error, rdata} the address map should return for this bus address
  function automatic logic [32:0] m_read(input logic [31:0] addr);
    int o, k;
    bit hi;
    o = int'(addr & 32'h3FF);
    if (o % 4 != 0) return {1'b1, 32'h0};
    case (o)
      0:  return {1'b0, 30'h0, m_irq_en, 1'b0};
      4:  return {1'b0, 30'h0, m_done, m_busy};
      8:  return {1'b0, m_cycles};
      12: return {1'b0, 8'(NI), 8'(NO), 8'h00, 8'h02};
      default: ;
    endcase
    if (o < 16) return {1'b1, 32'h0};
    k  = (o - 16) / 8;
    hi = ((o - 16) % 8) == 4;
    if (k < NI) return {1'b0, hi ? {m_in_stride[k], m_in_size[k]} : m_in_addr[k]};
    if (k < NI + NO) return {1'b0, hi ? {16'h0, m_out_size[k-NI]} : m_out_addr[k-NI]};
    return {1'b1, 32'h0};
  endfunction

  task automatic m_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    int o, k;
    logic [31:0] w;
    o = int'(addr & 32'h3FF);
    if (m_busy || o % 4 != 0 || o < 16) return;
    k = (o - 16) / 8;
    if (k >= NI + NO) return;
    w = merge(m_read(addr) & 32'hFFFF_FFFF, d, s);
    if (k < NI) begin
      if ((o - 16) % 8 == 4) begin m_in_size[k] = w[15:0]; m_in_stride[k] = w[31:16]; end
      else m_in_addr[k] = w;
    end else begin
      if ((o - 16) % 8 == 4) m_out_size[k-NI] = w[15:0];
      else m_out_addr[k-NI] = w;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s in_addr%0d", tag, i), in_addr[i], m_in_addr[i]);
      check($sformatf("%s in_size%0d", tag, i), 32'(in_size[i]), 32'(m_in_size[i]));
      check($sformatf("%s in_stride%0d", tag, i), 32'(in_stride[i]), 32'(m_in_stride[i]));
    end
    for (int j = 0; j < NO; j++) begin
      check($sformatf("%s out_addr%0d", tag, j), out_addr[j], m_out_addr[j]);
      check($sformatf("%s out_size%0d", tag, j), 32'(out_size[j]), 32'(m_out_size[j]));
    end
  endtask

  // called just after a negedge; drives one bus cycle and returns at the next negedge
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic dn);
    req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s; done_in = dn;
    #1;
    last_err = rsp.error; last_rdata = rsp.rdata;
    @(negedge clk);
    req.valid = 1'b0; req.write = 1'b0; done_in = 1'b0;
  endtask

  task automatic mstep(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic dn);
    if (m_busy && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    step(v, w, a, d, s, dn);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    req.valid = 1'b1; req.write = 1'b0; req.addr = a; req.wstrb = 4'h0;
    #1;
    d = rsp.rdata; e = rsp.error;
    req.valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a);
    logic [31:0] d;
    logic e;
    logic [32:0] exp;
    exp = m_read(a);
    rd(a, d, e);
    check({tag, " err"}, 32'(e), 32'(exp[32]));
    check({tag, " rdata"}, d, exp[31:0]);
  endtask

  initial begin
    logic [31:0] a, d, rdat;
    logic [3:0]  s;
    logic [32:0] exp;
    logic        e;
    int          exec_cnt, busy_cnt;

    req = '0; reqb = '0; done_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("rst busy", 32'(busy), 32'(m_busy));
    check("rst execute", 32'(execute), 0);
    check("rst irq", 32'(irq), 0);
    check_outputs("rst");

    // default-parameter instance
    reqb.valid = 1'b1; reqb.addr = 32'h10; #1;
    check("dflt 0x10 rdata", rspb.rdata, 32'h0); check("dflt 0x10 err", 32'(rspb.error), 0);
    reqb.addr = 32'h14; #1;
    check("dflt 0x14 rdata", rspb.rdata, 32'h0);
    reqb.addr = 32'h0C; #1;
    check("dflt version", rspb.rdata, 32'h0404_0002); check("dflt version err", 32'(rspb.error), 0);
    reqb.valid = 1'b0;
    @(negedge clk);

    rd_check("version", 32'h0C);
    rd(32'h3C, rdat, e);
    check("0x3C err", 32'(e), 1); check("0x3C rdata", rdat, 0);
    @(negedge clk);

    step(1, 1, 32'h20, 32'h9000_0040, 4'hF, 0); m_write(32'h20, 32'h9000_0040, 4'hF);
    check("out_addr0 write", out_addr[0], 32'h9000_0040);
    step(1, 1, 32'h14, 32'h0004_0050, 4'b0011, 0); m_write(32'h14, 32'h0004_0050, 4'b0011);
    check("in_size0 strobe", 32'(in_size[0]), 32'h50);
    check("in_stride0 strobe", 32'(in_stride[0]), 0);

    for (int it = 0; it < 40; it++) begin
      a = 32'(8 + 4 * $urandom_range(0, 19));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      a = ($urandom() & 32'hFFFF_FC00) | a;
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      exp = m_read(a);
      step(1, 1, a, d, s, 0);
      check("rnd wr err", 32'(last_err), 32'(exp[32]));
      m_write(a, d, s);
      check_outputs("rnd");
      a = 32'(4 * $urandom_range(0, 21));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      rd_check("rnd rd", a);
    end

    // run 1: ten busy cycles, done pulse in the last one
    mstep(1, 1, 32'h0, 32'h3, 4'h1, 0);
    m_irq_en = 1; m_busy = 1; m_done = 0; m_cycles = 0;
    exec_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      if (execute) exec_cnt++;
      if (busy) busy_cnt++;
      mstep(0, 0, 32'h0, 32'h0, 4'h0, k == 10);
    end
    m_busy = 0; m_done = 1;
    if (execute) exec_cnt++;
    check("run1 exec pulses", 32'(exec_cnt), 1);
    check("run1 busy cycles", 32'(busy_cnt), 10);
    check("run1 busy after", 32'(busy), 0);
    rd(32'h08, rdat, e); check("run1 cycles", rdat, 32'd10);
    rd_check("run1 status", 32'h04);
    check("run1 irq", 32'(irq), 1);
    step(1, 1, 32'h04, 32'h2, 4'h1, 0); m_done = 0;
    check("w1c irq", 32'(irq), 0);
    rd_check("w1c status", 32'h04);

    // run 2: lock, ignored restart, W1C racing completion
    mstep(1, 1, 32'h0, 32'h3, 4'h1, 0);
    m_busy = 1; m_cycles = 0;
    check("run2 execute", 32'(execute), 1);
    rd_check("run2 status", 32'h04);
    mstep(0, 0, 32'h0, 32'h0, 4'h0, 0);
    mstep(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    check("lock err", 32'(last_err), 0);
    m_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    check("lock in_addr0", in_addr[0], m_in_addr[0]);
    check("run2 exec idle", 32'(execute), 0);
    mstep(1, 1, 32'h0, 32'h1, 4'h1, 0); m_irq_en = 0;
    check("restart ignored", 32'(execute), 0);
    check("restart busy", 32'(busy), 1);
    mstep(1, 1, 32'h04, 32'h2, 4'h1, 1); m_busy = 0; m_done = 1;
    rd_check("set wins status", 32'h04);
    rd_check("run2 cycles", 32'h08);
    check("run2 irq masked", 32'(irq), 0);

    step(1, 1, 32'h04, 32'h2, 4'h1, 0); m_done = 0;
    mstep(0, 0, 32'h0, 32'h0, 4'h0, 1);
    rd_check("idle done ignored", 32'h04);

    mstep(1, 1, 32'h0, 32'h1, 4'h1, 1); m_busy = 1; m_cycles = 0;
    check("start beats done exec", 32'(execute), 1);
    rd_check("start beats done status", 32'h04);
    repeat (3) mstep(0, 0, 32'h0, 32'h0, 4'h0, 0);
    step(1, 1, 32'h0, 32'h4, 4'h1, 0); m_busy = 0; m_done = 0;
    check("soft clr busy", 32'(busy), 0);
    rd_check("soft clr cycles", 32'h08);
    step(1, 1, 32'h0, 32'h1, 4'b1110, 0);
    check("no strb0 exec", 32'(execute), 0);
    check("no strb0 busy", 32'(busy), 0);
    step(1, 1, 32'h0, 32'h5, 4'h1, 0); m_irq_en = 0;
    check("start+clr exec", 32'(execute), 0);
    check("start+clr busy", 32'(busy), 0);
    rd_check("start+clr ctrl", 32'h00);
    check_outputs("post clr");

    // asynchronous reset mid-run
    step(1, 1, 32'h0, 32'h3, 4'h1, 0);
    check("pre reset busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid reset busy", 32'(busy), 0);
    check("mid reset exec", 32'(execute), 0);
    check("mid reset irq", 32'(irq), 0);
    check_outputs("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("post reset status", 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
